// File: rtl/wf_pkg.sv
// Shared types and helpers for the pulse-period stagger sequencer.
// Holds the descriptor layout, FSM state encoding and the saturating adder.
package wf_pkg;

    localparam int WF_W     = 32;
    localparam int WF_AW    = 3;
    localparam int WF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [WF_W-1:0] dr;
        logic [WF_W-1:0] pw;
        logic [WF_W-1:0] df;
        logic [WF_W-1:0] pri;
    } pulse_desc_t;

    typedef struct packed {
        logic            sat;
        logic [WF_W-1:0] sum;
    } sat_sum_t;

    // Two guard bits keep the three-term sum exact before clamping to all-ones.
    function automatic sat_sum_t sat_add3(input logic [WF_W-1:0] a,
                                          input logic [WF_W-1:0] b,
                                          input logic [WF_W-1:0] c);
        logic [WF_W+1:0] full;
        sat_sum_t        r;
        full = {2'b00, a} + {2'b00, b} + {2'b00, c};
        if (full > {2'b00, {WF_W{1'b1}}}) begin
            r.sat = 1'b1;
            r.sum = {WF_W{1'b1}};
        end else begin
            r.sat = 1'b0;
            r.sum = full[WF_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_desc_table.sv
// Stagger table of pulse descriptors: synchronous write port, asynchronous
// read by index; out-of-range addresses are ignored on write and read as zero.
module pulse_desc_table
    import wf_pkg::*;
#(
    parameter int DEPTH = WF_DEPTH,
    parameter int AW    = WF_AW
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pulse_desc_t   wdata,
    input  logic [AW-1:0] raddr,
    output pulse_desc_t   rdata
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    pulse_desc_t mem_q [DEPTH];
    pulse_desc_t mem_d [DEPTH];

    // Next table contents: at most one entry replaced per write strobe.
    always_comb begin
        mem_d = mem_q;
        if (we && ({1'b0, waddr} < DEPTH_L)) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Asynchronous read of the selected descriptor.
    always_comb begin
        if ({1'b0, raddr} < DEPTH_L) begin
            rdata = mem_q[raddr];
        end else begin
            rdata = '0;
        end
    end

    // Table storage, cleared by reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pri_stagger_sequencer.sv
// Walks the pulse-period counter through the stagger table, loading each
// descriptor on the edge where the counter wraps so it is valid at count 0.
module pri_stagger_sequencer
    import wf_pkg::*;
#(
    parameter int DEPTH = WF_DEPTH,
    parameter int AW    = WF_AW,
    parameter int W     = WF_W
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_dr,
    input  logic [W-1:0]  cfg_pw,
    input  logic [W-1:0]  cfg_df,
    input  logic [W-1:0]  cfg_pri,
    input  logic [AW:0]   num_entries,
    input  logic [15:0]   burst_len,
    input  logic          start,
    input  logic          stop,
    output logic [W-1:0]  DR,
    output logic [W-1:0]  DR_PW,
    output logic [W-1:0]  PW_COVER,
    output logic [W-1:0]  PRI,
    output logic          cnt_nreset,
    output logic          busy,
    output logic          period_strobe,
    output logic [AW-1:0] entry_idx,
    output logic          done,
    output logic          sat_err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    seq_state_t    state_q, state_d;
    logic [W-1:0]  pcnt_q, pcnt_d;
    logic [15:0]   bcnt_q, bcnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic [W-1:0]  dr_q, dr_d;
    logic [W-1:0]  drpw_q, drpw_d;
    logic [W-1:0]  cover_q, cover_d;
    logic [W-1:0]  pri_q, pri_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          sat_err_q, sat_err_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          cnr_q, cnr_d;
    logic          strobe_q, strobe_d;

    pulse_desc_t   wr_desc_s, rd_desc_s;
    logic [AW-1:0] rd_idx_s, next_idx_s;
    logic [AW:0]   eff_n_s;
    logic          boundary_s, end_s, load_s;
    sat_sum_t      drpw_sum_s, cover_sum_s;

    assign wr_desc_s = '{dr: cfg_dr, pw: cfg_pw, df: cfg_df, pri: cfg_pri};

    pulse_desc_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk_in (clk_in),
        .reset  (reset),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wdata  (wr_desc_s),
        .raddr  (rd_idx_s),
        .rdata  (rd_desc_s)
    );

    assign drpw_sum_s  = sat_add3(rd_desc_s.dr, rd_desc_s.pw, {W{1'b0}});
    assign cover_sum_s = sat_add3(rd_desc_s.dr, rd_desc_s.pw, rd_desc_s.df);

    // Entry wrap point, period boundary and end-of-burst decode.
    always_comb begin
        if (num_entries == {(AW+1){1'b0}}) begin
            eff_n_s = (AW+1)'(1);
        end else if (num_entries > DEPTH_L) begin
            eff_n_s = DEPTH_L;
        end else begin
            eff_n_s = num_entries;
        end
        if (({1'b0, idx_q} + (AW+1)'(1)) >= eff_n_s) begin
            next_idx_s = {AW{1'b0}};
        end else begin
            next_idx_s = idx_q + AW'(1);
        end
        boundary_s = (state_q == RUN) && (pcnt_q >= pri_q);
        end_s      = ((burst_len != 16'd0) &&
                      (({1'b0, bcnt_q} + 17'd1) == {1'b0, burst_len})) ||
                     stop_pend_q || stop;
        rd_idx_s   = (state_q == RUN) ? next_idx_s : {AW{1'b0}};
    end

    // Sequencer FSM, period/burst counters and descriptor loading.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        bcnt_d      = bcnt_q;
        stop_pend_d = stop_pend_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    idx_d   = {AW{1'b0}};
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                pcnt_d  = {W{1'b0}};
                bcnt_d  = 16'd0;
                state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (boundary_s) begin
                    pcnt_d = {W{1'b0}};
                    bcnt_d = bcnt_q + 16'd1;
                    if (end_s) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        load_s = 1'b1;
                        idx_d  = next_idx_s;
                    end
                end else begin
                    pcnt_d = pcnt_q + W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Derived parameter registers; sat_err only ever accumulates.
    always_comb begin
        if (load_s) begin
            dr_d      = rd_desc_s.dr;
            pri_d     = rd_desc_s.pri;
            drpw_d    = drpw_sum_s.sum;
            cover_d   = cover_sum_s.sum;
            sat_err_d = sat_err_q | drpw_sum_s.sat | cover_sum_s.sat;
        end else begin
            dr_d      = dr_q;
            pri_d     = pri_q;
            drpw_d    = drpw_q;
            cover_d   = cover_q;
            sat_err_d = sat_err_q;
        end
        busy_d   = (state_d != IDLE);
        cnr_d    = (state_d == RUN);
        strobe_d = (state_d == RUN) && (pcnt_d >= pri_d);
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pcnt_q      <= {W{1'b0}};
            bcnt_q      <= 16'd0;
            stop_pend_q <= 1'b0;
            dr_q        <= {W{1'b0}};
            drpw_q      <= {W{1'b0}};
            cover_q     <= {W{1'b0}};
            pri_q       <= {W{1'b0}};
            idx_q       <= {AW{1'b0}};
            sat_err_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cnr_q       <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            bcnt_q      <= bcnt_d;
            stop_pend_q <= stop_pend_d;
            dr_q        <= dr_d;
            drpw_q      <= drpw_d;
            cover_q     <= cover_d;
            pri_q       <= pri_d;
            idx_q       <= idx_d;
            sat_err_q   <= sat_err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cnr_q       <= cnr_d;
            strobe_q    <= strobe_d;
        end
    end

    assign DR            = dr_q;
    assign DR_PW         = drpw_q;
    assign PW_COVER      = cover_q;
    assign PRI           = pri_q;
    assign cnt_nreset    = cnr_q;
    assign busy          = busy_q;
    assign period_strobe = strobe_q;
    assign entry_idx     = idx_q;
    assign done          = done_q;
    assign sat_err       = sat_err_q;

endmodule

// File: tb/tb_pri_stagger_sequencer.sv
// Self-checking bench for pri_stagger_sequencer: directed and random runs
// compared cycle by cycle against a period-level reference model.
module tb_pri_stagger_sequencer;

    localparam int     W     = 32;
    localparam int     AW    = 3;
    localparam int     DEPTH = 8;
    localparam longint MAXV  = 64'h0000_0000_FFFF_FFFF;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_dr, cfg_pw, cfg_df, cfg_pri;
    logic [AW:0]   num_entries;
    logic [15:0]   burst_len;
    logic          start, stop;
    logic [W-1:0]  DR, DR_PW, PW_COVER, PRI;
    logic          cnt_nreset, busy, period_strobe, done, sat_err;
    logic [AW-1:0] entry_idx;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint t_dr [DEPTH];
    longint t_pw [DEPTH];
    longint t_df [DEPTH];
    longint t_pri[DEPTH];
    longint m_dr, m_drpw, m_cover, m_pri;
    int     m_idx;
    bit     m_sat;

    always #5 clk_in = ~clk_in;

    pri_stagger_sequencer dut (
        .clk_in(clk_in), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_dr(cfg_dr), .cfg_pw(cfg_pw), .cfg_df(cfg_df), .cfg_pri(cfg_pri),
        .num_entries(num_entries), .burst_len(burst_len), .start(start), .stop(stop),
        .DR(DR), .DR_PW(DR_PW), .PW_COVER(PW_COVER), .PRI(PRI),
        .cnt_nreset(cnt_nreset), .busy(busy), .period_strobe(period_strobe),
        .entry_idx(entry_idx), .done(done), .sat_err(sat_err)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph, input logic b, input logic cn,
                              input logic st, input logic dn);
        chk({ph, ".DR"},        64'(DR),            m_dr);
        chk({ph, ".DR_PW"},     64'(DR_PW),         m_drpw);
        chk({ph, ".PW_COVER"},  64'(PW_COVER),      m_cover);
        chk({ph, ".PRI"},       64'(PRI),           m_pri);
        chk({ph, ".entry_idx"}, 64'(entry_idx),     64'(m_idx));
        chk({ph, ".sat_err"},   64'(sat_err),       64'(m_sat));
        chk({ph, ".busy"},      64'(busy),          64'(b));
        chk({ph, ".cnt_nreset"},64'(cnt_nreset),    64'(cn));
        chk({ph, ".strobe"},    64'(period_strobe), 64'(st));
        chk({ph, ".done"},      64'(done),          64'(dn));
    endtask

    function automatic longint sat32(input longint s);
        return (s > MAXV) ? MAXV : s;
    endfunction

    function automatic int eff_entries();
        int ne;
        ne = int'(num_entries);
        if (ne == 0) return 1;
        if (ne > DEPTH) return DEPTH;
        return ne;
    endfunction

    task automatic m_load(input int i);
        m_idx   = i;
        m_dr    = t_dr[i];
        m_pri   = t_pri[i];
        if ((t_dr[i] + t_pw[i] > MAXV) || (t_dr[i] + t_pw[i] + t_df[i] > MAXV)) m_sat = 1'b1;
        m_drpw  = sat32(t_dr[i] + t_pw[i]);
        m_cover = sat32(t_dr[i] + t_pw[i] + t_df[i]);
    endtask

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            t_dr[i] = 0; t_pw[i] = 0; t_df[i] = 0; t_pri[i] = 0;
        end
        m_dr = 0; m_drpw = 0; m_cover = 0; m_pri = 0; m_idx = 0; m_sat = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [31:0] p,
                      input logic [31:0] f, input logic [31:0] r);
        cfg_we = 1'b1; cfg_addr = AW'(a);
        cfg_dr = d; cfg_pw = p; cfg_df = f; cfg_pri = r;
        step();
        cfg_we = 1'b0;
        t_dr[a] = longint'(d); t_pw[a] = longint'(p);
        t_df[a] = longint'(f); t_pri[a] = longint'(r);
    endtask

    // ev_kind: 0 none, 1 stop, 2 rewrite entry1 PRI=ev_val, 3 start while running
    task automatic run_seq(input string nm, input int ev_per, input int ev_cyc,
                           input int ev_kind, input logic [31:0] ev_val, input int max_per);
        int per, plen, bc;
        bit ending, stop_pend, stop_now;
        logic [31:0] tmp;
        start = 1'b1;
        step();
        start = 1'b0;
        m_load(0);
        check_outs({nm, "/arm"}, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        ending = 1'b0; stop_pend = 1'b0; bc = 0; per = 0;
        while (!ending && per < max_per) begin
            plen = int'(m_pri);
            for (int c = 0; c <= plen; c++) begin
                check_outs({nm, "/run"}, 1'b1, 1'b1, (c == plen), 1'b0);
                stop_now = 1'b0;
                if (per == ev_per && c == ev_cyc) begin
                    case (ev_kind)
                        1: begin stop = 1'b1; stop_now = 1'b1; end
                        2: begin
                            cfg_we = 1'b1; cfg_addr = 3'd1;
                            tmp = t_dr[1][31:0]; cfg_dr = tmp;
                            tmp = t_pw[1][31:0]; cfg_pw = tmp;
                            tmp = t_df[1][31:0]; cfg_df = tmp;
                            cfg_pri = ev_val; t_pri[1] = longint'(ev_val);
                        end
                        3: start = 1'b1;
                        default: ;
                    endcase
                end
                if (c == plen) begin
                    bc++;
                    ending = ((burst_len != 16'd0) && (bc == int'(burst_len))) || stop_pend || stop_now;
                end else if (stop_now) begin
                    stop_pend = 1'b1;
                end
                step();
                stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
                if (c == plen && !ending) m_load((m_idx + 1) % eff_entries());
            end
            per++;
        end
        check_outs({nm, "/end"}, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_outs({nm, "/idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0;
        cfg_dr = '0; cfg_pw = '0; cfg_df = '0; cfg_pri = '0;
        num_entries = '0; burst_len = 16'd0; start = 1'b0; stop = 1'b0;
        m_clear();
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #10 reset = 1'b0;
        step();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // stop while idle has no effect
        stop = 1'b1; step(); stop = 1'b0; step();
        check_outs("idle_stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // single entry, continuous, graceful stop at pcnt=3 of the third period
        wr(0, 32'd2, 32'd3, 32'd1, 32'd9);
        num_entries = 4'd1; burst_len = 16'd0;
        run_seq("single_stop", 2, 3, 1, 32'd0, 10);

        // two-entry stagger with a 3-period burst
        wr(1, 32'd0, 32'd1, 32'd0, 32'd4);
        num_entries = 4'd2; burst_len = 16'd3;
        run_seq("stagger_burst", -1, 0, 0, 32'd0, 5);

        // rewrite entry1 PRI while entry0 is active
        burst_len = 16'd4;
        run_seq("write_in_run", 0, 4, 2, 32'd7, 6);

        // start pulsed during RUN is ignored
        burst_len = 16'd2;
        run_seq("start_in_run", 0, 2, 3, 32'd0, 4);

        // saturating DR+PW, sat_err sticky afterwards
        wr(0, 32'hFFFF_FFF0, 32'h0000_0020, 32'd0, 32'd3);
        num_entries = 4'd1; burst_len = 16'd2;
        run_seq("saturate", -1, 0, 0, 32'd0, 4);

        // randomized tables, entry counts, burst lengths and stop points
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                wr(e, $urandom, $urandom, $urandom, 32'($urandom_range(0, 6)));
            end
            num_entries = 4'($urandom_range(0, 15));
            burst_len   = 16'($urandom_range(1, 6));
            run_seq("random", int'($urandom_range(0, 7)), 0, 1, 32'd0, 8);
        end

        // asynchronous reset in the middle of a run
        wr(0, 32'd2, 32'd3, 32'd1, 32'd9);
        num_entries = 4'd1; burst_len = 16'd0;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        #2 reset = 1'b1;
        #1;
        m_clear();
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b0;
        step();
        check_outs("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // table was cleared: entry0 is all zero, one-clock period
        num_entries = 4'd1; burst_len = 16'd1;
        run_seq("cleared_table", -1, 0, 0, 32'd0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
